// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control bundle between the instruction sequencer and the CPU datapath.
//   master : sequencer side. It receives opcode, zero and stall, and drives the strobes and phase.
//   slave  : datapath side. It drives opcode, zero and stall, and receives the strobes and phase.
//   opcode : IR opcode field (0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP).
//   zero   : accumulator-equals-zero flag.
//   stall  : memory not ready.
//   sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e : datapath control strobes.
//   halt   : CPU halted. phase : current sequencer phase, for trace.
interface cpu_sequencer_if;
   logic [2:0] opcode;
   logic       zero;
   logic       stall;
   logic       sel;
   logic       rd;
   logic       wr;
   logic       ld_ir;
   logic       ld_ac;
   logic       ld_pc;
   logic       inc_pc;
   logic       data_e;
   logic       halt;
   logic [2:0] phase;

   modport master (
      input  opcode, zero, stall,
      output sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
   );

   modport slave (
      output opcode, zero, stall,
      input  sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
   );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase instruction sequencer for the 5-bit-address RISC CPU.
// Each instruction takes one pass through phases 0..7. Every datapath strobe is decoded
// combinationally from the phase, the IR opcode and the accumulator zero flag.
// Ports:
//   clk  : clock, rising edge.
//   rst  : asynchronous, active-high reset. It forces phase 0, clears halt, and zeroes all strobes.
//   bus  : cpu_sequencer_if.master. It carries opcode/zero/stall in and the strobes, halt and
//          phase out.
// Parameters:
//   STALL_EN : 1 lets stall freeze the phase counter. 0 ignores stall.
module cpu_sequencer #(
   parameter bit STALL_EN = 1'b1
) (
   input logic             clk,
   input logic             rst,
   cpu_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      PhInstAddr  = 3'd0,
      PhInstFetch = 3'd1,
      PhInstLoad  = 3'd2,
      PhIdle      = 3'd3,
      PhOpAddr    = 3'd4,
      PhOpFetch   = 3'd5,
      PhAluOp     = 3'd6,
      PhStore     = 3'd7
   } phase_e;

   localparam logic [2:0] OpHlt = 3'd0;
   localparam logic [2:0] OpSkz = 3'd1;
   localparam logic [2:0] OpAdd = 3'd2;
   localparam logic [2:0] OpAnd = 3'd3;
   localparam logic [2:0] OpXor = 3'd4;
   localparam logic [2:0] OpLda = 3'd5;
   localparam logic [2:0] OpSto = 3'd6;
   localparam logic [2:0] OpJmp = 3'd7;

   phase_e phase_q, phase_d;
   logic   halted_q, halted_d;

   logic   stalled;
   logic   is_hlt, is_skz, is_sto, is_jmp, is_aluop;
   logic   hlt_now;
   logic   skip;

   assign stalled  = STALL_EN & bus.stall;
   assign is_hlt   = (bus.opcode == OpHlt);
   assign is_skz   = (bus.opcode == OpSkz);
   assign is_sto   = (bus.opcode == OpSto);
   assign is_jmp   = (bus.opcode == OpJmp);
   assign is_aluop = (bus.opcode == OpAdd) | (bus.opcode == OpAnd) |
                     (bus.opcode == OpXor) | (bus.opcode == OpLda);
   // HLT is visible on halt as soon as phase 4 decodes it, before the sticky flag sets.
   assign hlt_now  = (phase_q == PhOpAddr) & is_hlt;
   assign skip     = is_skz & bus.zero;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= PhInstAddr;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // Next state
   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (!halted_q && !stalled) begin
         if (hlt_now) begin
            // Freeze in phase 4 on the same edge that sets the sticky flag.
            halted_d = 1'b1;
         end else begin
            phase_d = phase_e'(phase_q + 3'd1);
         end
      end
   end

   // Output decode
   always_comb begin
      bus.sel    = 1'b0;
      bus.rd     = 1'b0;
      bus.wr     = 1'b0;
      bus.ld_ir  = 1'b0;
      bus.ld_ac  = 1'b0;
      bus.ld_pc  = 1'b0;
      bus.inc_pc = 1'b0;
      bus.data_e = 1'b0;
      bus.halt   = halted_q | hlt_now;
      bus.phase  = phase_q;

      if (!halted_q) begin
         unique case (phase_q)
            PhInstAddr: begin
               bus.sel = 1'b1;
            end
            PhInstFetch: begin
               bus.sel = 1'b1;
               bus.rd  = 1'b1;
            end
            PhInstLoad, PhIdle: begin
               bus.sel   = 1'b1;
               bus.rd    = 1'b1;
               bus.ld_ir = 1'b1;
            end
            PhOpAddr: begin
               bus.inc_pc = ~is_hlt;
            end
            PhOpFetch: begin
               bus.rd = is_aluop;
            end
            // The PC acts on inc_pc/ld_pc only at the phase 7 edge. The phase 6 pulse is
            // set up early and does not cause a second step.
            PhAluOp: begin
               bus.rd     = is_aluop;
               bus.inc_pc = skip;
               bus.ld_pc  = is_jmp;
               bus.data_e = is_sto;
            end
            PhStore: begin
               bus.rd     = is_aluop;
               bus.ld_ac  = is_aluop;
               bus.inc_pc = skip;
               bus.ld_pc  = is_jmp;
               bus.wr     = is_sto;
               bus.data_e = is_sto;
            end
            default: ;
         endcase
      end

      // Reset overrides the decode at once, so an abort in phase 6/7 never leaks wr or ld_pc.
      if (rst) begin
         bus.sel    = 1'b0;
         bus.rd     = 1'b0;
         bus.wr     = 1'b0;
         bus.ld_ir  = 1'b0;
         bus.ld_ac  = 1'b0;
         bus.ld_pc  = 1'b0;
         bus.inc_pc = 1'b0;
         bus.data_e = 1'b0;
         bus.halt   = 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed self-checking bench for cpu_sequencer.
// It runs two instances side by side: dut with STALL_EN=1 and dut_ns with STALL_EN=0.
// Both instances share the same inputs.
module tb_cpu_sequencer;

   logic clk;
   logic rst;

   cpu_sequencer_if ifa ();
   cpu_sequencer_if ifb ();

   assign ifb.opcode = ifa.opcode;
   assign ifb.zero   = ifa.zero;
   assign ifb.stall  = ifa.stall;

   cpu_sequencer #(.STALL_EN(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifa.master)
   );

   cpu_sequencer #(.STALL_EN(1'b0)) dut_ns (
      .clk (clk),
      .rst (rst),
      .bus (ifb.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Strobe vector: {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}
   localparam logic [8:0] V_SEL   = 9'b100000000;
   localparam logic [8:0] V_FETCH = 9'b110000000;
   localparam logic [8:0] V_LOAD  = 9'b110100000;
   localparam logic [8:0] V_INC   = 9'b000000100;
   localparam logic [8:0] V_HALT  = 9'b000000001;

   // Rows: 0 ADD, 1 SKZ zero=1, 2 SKZ zero=0, 3 STO, 4 JMP
   localparam logic [8:0] TAB [0:4][0:7] = '{
      '{V_SEL, V_FETCH, V_LOAD, V_LOAD, V_INC, 9'b010000000, 9'b010000000, 9'b010010000},
      '{V_SEL, V_FETCH, V_LOAD, V_LOAD, V_INC, 9'b000000000, V_INC,        V_INC       },
      '{V_SEL, V_FETCH, V_LOAD, V_LOAD, V_INC, 9'b000000000, 9'b000000000, 9'b000000000},
      '{V_SEL, V_FETCH, V_LOAD, V_LOAD, V_INC, 9'b000000000, 9'b000000010, 9'b001000010},
      '{V_SEL, V_FETCH, V_LOAD, V_LOAD, V_INC, 9'b000000000, 9'b000001000, 9'b000001000}
   };

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [8:0] outs_a();
      return {ifa.sel, ifa.rd, ifa.wr, ifa.ld_ir, ifa.ld_ac, ifa.ld_pc, ifa.inc_pc,
              ifa.data_e, ifa.halt};
   endfunction

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                            input int row);
      ifa.opcode = op;
      ifa.zero   = z;
      #1;
      for (int p = 0; p < 8; p++) begin
         check_eq($sformatf("%s_phase%0d", name, p), 32'(ifa.phase), 32'(p));
         check_eq($sformatf("%s_outs%0d", name, p), 32'(outs_a()), 32'(TAB[row][p]));
         step();
      end
      check_eq({name, "_wrap"}, 32'(ifa.phase), 32'd0);
   endtask

   int cyc;
   int ns_len;
   int wr_cnt;
   bit ns_done;

   task automatic stall_step();
      step();
      cyc++;
      if (ifa.wr) wr_cnt++;
      if (!ns_done && ifb.phase == 3'd0) begin
         ns_len  = cyc;
         ns_done = 1'b1;
      end
   endtask

   initial begin
      rst        = 1'b1;
      ifa.opcode = 3'd6;
      ifa.zero   = 1'b0;
      ifa.stall  = 1'b0;

      // Reset, then an abort in the middle of phase 6 of a STO.
      step();
      step();
      check_eq("rst_phase", 32'(ifa.phase), 32'd0);
      check_eq("rst_outs", 32'(outs_a()), 32'd0);
      rst = 1'b0;
      repeat (6) step();
      check_eq("pre_abort_phase", 32'(ifa.phase), 32'd6);
      check_eq("pre_abort_outs", 32'(outs_a()), 32'(TAB[3][6]));
      #2 rst = 1'b1;
      #1;
      check_eq("abort_phase", 32'(ifa.phase), 32'd0);
      check_eq("abort_outs", 32'(outs_a()), 32'd0);
      step();
      check_eq("abort_hold_outs", 32'(outs_a()), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("release_outs", 32'(outs_a()), 32'(V_SEL));
      for (int p = 0; p < 8; p++) begin
         check_eq($sformatf("release_phase%0d", p), 32'(ifa.phase), 32'(p));
         step();
      end

      run_instr("add", 3'd2, 1'b0, 0);
      run_instr("skz1", 3'd1, 1'b1, 1);
      run_instr("skz0", 3'd1, 1'b0, 2);
      run_instr("sto", 3'd6, 1'b0, 3);
      run_instr("jmp", 3'd7, 1'b0, 4);

      // HLT: it sticks in phase 4 with only halt asserted.
      ifa.opcode = 3'd0;
      repeat (4) step();
      check_eq("hlt_phase4", 32'(ifa.phase), 32'd4);
      check_eq("hlt_outs4", 32'(outs_a()), 32'(V_HALT));
      for (int i = 0; i < 20; i++) begin
         step();
         check_eq($sformatf("hlt_hold_phase%0d", i), 32'(ifa.phase), 32'd4);
         check_eq($sformatf("hlt_hold_outs%0d", i), 32'(outs_a()), 32'(V_HALT));
      end
      rst = 1'b1;
      #1;
      check_eq("hlt_rst_phase", 32'(ifa.phase), 32'd0);
      check_eq("hlt_rst_halt", 32'(ifa.halt), 32'd0);
      step();
      rst = 1'b0;
      #1;
      check_eq("hlt_after_outs", 32'(outs_a()), 32'(V_SEL));

      // Stall: 3 cycles in phase 1, then STO with 2 cycles in phase 7.
      ifa.opcode = 3'd6;
      cyc     = 0;
      wr_cnt  = 0;
      ns_len  = 0;
      ns_done = 1'b0;
      stall_step();
      check_eq("stall_enter1", 32'(ifa.phase), 32'd1);
      ifa.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stall_step();
         check_eq($sformatf("stall_p1_phase%0d", i), 32'(ifa.phase), 32'd1);
         check_eq($sformatf("stall_p1_outs%0d", i), 32'(outs_a()), 32'(V_FETCH));
      end
      ifa.stall = 1'b0;
      for (int p = 2; p < 8; p++) begin
         stall_step();
         check_eq($sformatf("stall_run_phase%0d", p), 32'(ifa.phase), 32'(p));
      end
      check_eq("stall_p7_wr", 32'(ifa.wr), 32'd1);
      ifa.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         stall_step();
         check_eq($sformatf("stall_p7_phase%0d", i), 32'(ifa.phase), 32'd7);
         check_eq($sformatf("stall_p7_outs%0d", i), 32'(outs_a()), 32'(TAB[3][7]));
      end
      ifa.stall = 1'b0;
      stall_step();
      check_eq("stall_done_phase", 32'(ifa.phase), 32'd0);
      check_eq("stall_cycles", 32'(cyc), 32'd13);
      check_eq("stall_wr_cycles", 32'(wr_cnt), 32'd3);
      check_eq("nostall_done", 32'(ns_done), 32'd1);
      check_eq("nostall_cycles", 32'(ns_len), 32'd8);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Eight-phase instruction sequencer for the 5-bit-address RISC CPU.
- Generates every datapath control strobe for one instruction per 8-phase cycle:
  - program counter: inc_pc, ld_pc
  - memory: rd, wr, sel
  - instruction register: ld_ir
  - accumulator: ld_ac
  - bus driver: data_e
- Decodes the 3-bit opcode from the instruction register and the accumulator zero flag.
- Supports a memory-wait stall and a sticky halt.

Parameters:
- STALL_EN, 1, when 1 the stall input freezes the phase counter; when 0 stall is ignored.

Ports:
- clk     input   1  clock, rising edge
- rst     input   1  reset, asynchronous, active-high
- opcode  input   3  IR opcode field; 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP
- zero    input   1  accumulator-equals-zero flag
- stall   input   1  memory not ready; hold current phase
- sel     output  1  address mux select: 1 = PC, 0 = IR operand
- rd      output  1  memory read enable
- wr      output  1  memory write enable
- ld_ir   output  1  load instruction register
- ld_ac   output  1  load accumulator
- ld_pc   output  1  load PC from operand (jump)
- inc_pc  output  1  increment PC
- data_e  output  1  drive accumulator onto data bus
- halt    output  1  CPU halted (sticky)
- phase   output  3  current phase, for debug/trace

Behaviour:
- State:
  - 3-bit phase register: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
  - 1-bit halted register.
- Reset:
  - While rst=1: phase=0, halted=0, and all control outputs (sel..data_e, halt) are forced 0.
  - rst is asynchronous, mid-instruction included: it aborts immediately with no partial wr or ld_pc.
- Phase advance, each rising clk:
  - If halted, or (stall && STALL_EN): phase holds.
  - Otherwise phase <= phase+1, wrapping 7 -> 0.
- Halt:
  - In phase 4 with opcode==HLT and not stalled, halted <= 1 on the clock edge; phase holds at 4 thereafter.
  - halt output = 1 combinationally during phase 4 when opcode==HLT, and = 1 whenever halted.
  - Only rst clears halted.
  - While halted, every other control output = 0.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Output decode: combinational from phase, opcode, zero (Moore on phase, Mealy on opcode/zero). Strobes not listed for a phase are 0.
  - phase 0: sel=1.
  - phase 1: sel=1, rd=1.
  - phase 2: sel=1, rd=1, ld_ir=1.
  - phase 3: sel=1, rd=1, ld_ir=1.
  - phase 4: inc_pc=1 unless opcode==HLT; halt per the Halt rules above.
  - phase 5: rd=ALUOP.
  - phase 6:
    - rd=ALUOP
    - inc_pc=(SKZ && zero)
    - ld_pc=JMP
    - data_e=STO
  - phase 7:
    - rd=ALUOP
    - ld_ac=ALUOP
    - inc_pc=(SKZ && zero)
    - ld_pc=JMP
    - wr=STO
    - data_e=STO
- PC strobe timing:
  - inc_pc and ld_pc are never both 1 in one cycle.
  - The PC sees one effective increment per qualifying phase edge.
  - SKZ with zero=1 skips exactly one word: the phase 6/7 pulses form one effective increment because the PC acts on the phase 7 edge only (ld_pc has the same property).
  - This requires the PC instance to qualify inc_pc/ld_pc with (phase==7 || phase==4).
- Sampling:
  - opcode is ignored in phases 0-3; it is valid from phase 3 onward, after ld_ir.
  - zero is used only in phases 6-7.
- Stall:
  - Outputs remain those of the held phase for the whole stall.
  - A stall in phase 7 with STO keeps wr=1 for multiple cycles; memory treats a held wr as one write.
- Latency: one instruction = 8 unstalled cycles; N stalled cycles add N.

Test Plan:
- Reset release:
  - Stimulus: rst high mid-phase 6 with opcode=STO, then low.
  - Required: while rst high, all outputs 0 and phase=0. After release, phase 0 shows sel=1 only, then phase goes 1..7 on successive clocks.
- ADD instruction:
  - Stimulus: opcode=2, zero=0, no stall.
  - Required:
    - phases 0-3 match the table.
    - phase 4: inc_pc=1.
    - phases 5-7: rd=1.
    - phase 7: ld_ac=1.
    - wr, ld_pc, data_e stay 0 throughout.
    - phase returns to 0 after 8 clocks.
- SKZ:
  - Stimulus: opcode=1, run once with zero=1 and once with zero=0.
  - Required: with zero=1, inc_pc=1 in phases 4, 6 and 7. With zero=0, inc_pc=1 in phase 4 only.
- STO then JMP:
  - Required for opcode=6: data_e=1 in phases 6-7, wr=1 only in phase 7.
  - Required for opcode=7: ld_pc=1 in phases 6-7, inc_pc=0 in phases 6-7.
- HLT:
  - Stimulus: opcode=0, run 20 further clocks.
  - Required: halt=1 from phase 4 and persists; phase stays 4; all other outputs 0. A rst pulse returns phase to 0 with halt=0.
- Stall:
  - Stimulus: stall=1 for 3 cycles in phase 1, then opcode=6 with stall=1 for 2 cycles in phase 7.
  - Required:
    - In phase 1, phase holds with sel=rd=1 for 3 extra cycles.
    - In phase 7, wr=1 held for 3 cycles total.
    - The instruction completes in 13 cycles.
    - With STALL_EN=0, the same stimulus completes in 8 cycles.
